retry_inorder_scheduler: RTL
============================

RETRY_INORDER_SCHEDULER -- requirements
Module: retry_inorder_scheduler

Interface
REQ-001 The block SHALL have parameter DataType, default logic, meaning the payload type.
REQ-002 The block SHALL have parameter IDSize, default 2, meaning ID width; replay depth DEPTH = 2**IDSize.
REQ-003 Ports SHALL be exactly as listed in REQ-003a to REQ-003p; one clock; reset is asynchronous and active-high.
REQ-003a clk_i  in  1  clock, all state on rising edge.
REQ-003b rst_i  in  1  asynchronous active-high reset.
REQ-003c data_i  in  DataType  new upstream item.
REQ-003d valid_i  in  1  upstream valid.
REQ-003e ready_o  out  1  upstream ready.
REQ-003f data_o  out  DataType  item issued to the redundant datapath.
REQ-003g id_o  out  IDSize  ID of the issued item.
REQ-003h valid_o  out  1  issue valid.
REQ-003i ready_i  in  1  issue ready.
REQ-003j retry_id_i  in  IDSize  ID of the item that needs retry, from the retry end stage.
REQ-003k retry_valid_i  in  1  retry request valid.
REQ-003l retry_ready_o  out  1  retry ready; tied high.
REQ-003m retry_lock_i  in  1  end stage is discarding items until the failed ID returns.
REQ-003n commit_i  in  1  oldest in-flight item left the end stage; its slot is freed.
REQ-003o busy_o  out  1  the scheduler is in REPLAY.
REQ-003p retry_count_o  out  16  number of replays started; present only with the macro in REQ-021.

Function
REQ-004 The block SHALL store every issued new item in slot wr_ptr of a DEPTH-entry buffer and SHALL output id_o = wr_ptr on that issue.
REQ-005 wr_ptr SHALL advance by one on each NORMAL issue handshake (valid_o & ready_i).
REQ-006 All pointer arithmetic SHALL be modulo DEPTH.
REQ-007 occ (0..DEPTH) SHALL change as follows:
- +1 on each NORMAL issue handshake.
- -1 on each commit_i.
- unchanged when both occur in the same cycle.
- a commit_i while occ==0 SHALL be ignored.
REQ-008 The FSM SHALL have two states, NORMAL and REPLAY, and SHALL reset to NORMAL.
REQ-009 In NORMAL, the issue path SHALL be combinational pass-through:
- valid_o = valid_i & (occ<DEPTH).
- ready_o = ready_i & (occ<DEPTH).
- data_o = data_i.
REQ-010 A retry handshake SHALL be "first" when retry_valid_i is high and retry_lock_i was low in the previous cycle (registered lock).
REQ-011 A first retry handshake SHALL set rp_ptr = retry_id_i and SHALL move the FSM to REPLAY next cycle, from either state.
REQ-012 Non-first retry handshakes SHALL be accepted and discarded, with no state change.
REQ-013 In REPLAY, the issue outputs SHALL be:
- data_o = buffer[rp_ptr].
- id_o = rp_ptr.
- valid_o = 1.
- ready_o = 0.
- rp_ptr advances on each issue handshake.
REQ-014 In REPLAY, a handshake when rp_ptr+1 == wr_ptr SHALL return the FSM to NORMAL next cycle.
REQ-015 A first retry arriving in the same cycle as a replay handshake SHALL take priority, reloading rp_ptr.
REQ-016 Replay SHALL neither change occ nor overwrite buffer slots.
REQ-017 A retry_id_i outside the in-flight window (occ==0) SHALL be ignored, and the FSM SHALL stay in NORMAL.
REQ-018 busy_o SHALL be 1 exactly when the FSM is in REPLAY.

Reset
REQ-019 While rst_i is high, the block SHALL hold:
- FSM = NORMAL.
- wr_ptr = 0, rp_ptr = 0, occ = 0.
- registered lock = 0.
- busy_o = 0.
- retry_count_o = 0.
- valid_o = 0, regardless of valid_i.
REQ-020 Reset asserted mid-replay SHALL abandon the replay; buffer contents need not be cleared.

Configuration
REQ-021 With macro RETRY_SCHED_STATS_EN defined, the block SHALL provide retry_count_o, a 16-bit counter that increments on each first retry and saturates at 16'hFFFF.
REQ-022 Without the macro, the port and counter SHALL be absent, and the behaviour SHALL otherwise be identical.

Structure
REQ-023 A shared package retry_sched_pkg SHALL hold the FSM state enum (NORMAL, REPLAY).
REQ-024 The storage array SHALL be a sub-module retry_sched_buffer: one write port (addr, data, we) and one asynchronous read port, with no reset on data.

Verification
REQ-025 The bench SHALL cover the following directed scenarios, IDSize=2:
- Issue A,B,C with ready_i=1 -> id_o 0,1,2; occ=3.
- With occ=4 -> ready_o=0 and valid_o=0; one commit_i -> next item issues with id_o=0.
- With A..D in flight, first retry with id 1 -> busy_o=1; reissues B(1), C(2), D(3) with ready_o=0; then NORMAL.
- Retry handshakes while retry_lock_i is held high -> no rp_ptr change; retry_count_o increments by 1 only.
- New first retry with id 2 in the same cycle as a replay handshake on id 1 -> next issue is id 2.
- rst_i pulsed during REPLAY -> busy_o=0, occ=0, and the next new item issues with id_o=0.

Source files
------------

// File: rtl/retry_sched_pkg.sv
// Shared definitions for the retry in-order scheduler.
package retry_sched_pkg;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        REPLAY = 1'b1
    } sched_state_e;

endpackage

// File: rtl/retry_sched_buffer.sv
// Replay storage: one synchronous write port, one asynchronous read port.
// Data is deliberately not reset; slots are always written before being read back.
module retry_sched_buffer #(
    parameter type         DataType = logic,
    parameter int unsigned AddrW    = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  DataType          wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output DataType          rdata_o
);

    DataType mem_q [0:(2**AddrW)-1];

    // Slot write on each accepted new item.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/retry_inorder_scheduler.sv
// Issues new items in order and replays from a failed ID when the end stage asks.
// Optional replay counter port retry_count_o is built when RETRY_SCHED_STATS_EN is defined.
module retry_inorder_scheduler
    import retry_sched_pkg::*;
#(
    parameter type         DataType = logic,
    parameter int unsigned IDSize   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  DataType           data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic [IDSize-1:0] retry_id_i,
    input  logic              retry_valid_i,
    output logic              retry_ready_o,
    input  logic              retry_lock_i,
    input  logic              commit_i,
    output logic              busy_o
`ifdef RETRY_SCHED_STATS_EN
    ,
    output logic [15:0]       retry_count_o
`endif
);

    localparam int unsigned       Depth    = 2**IDSize;
    localparam logic [IDSize:0]   DepthCnt = (IDSize+1)'(Depth);

    sched_state_e      state_q, state_d;
    logic [IDSize-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDSize-1:0] rp_ptr_q, rp_ptr_d;
    logic [IDSize:0]   occ_q, occ_d;
    logic              lock_q;

    logic              not_full_s;
    logic              issue_hs_s;
    logic              normal_hs_s;
    logic              replay_hs_s;
    logic              first_retry_s;
    logic              commit_eff_s;
    logic [IDSize-1:0] rp_inc_s;
    DataType           rd_data_s;

    retry_sched_buffer #(
        .DataType (DataType),
        .AddrW    (IDSize)
    ) u_buffer (
        .clk_i   (clk_i),
        .we_i    (normal_hs_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rp_ptr_q),
        .rdata_o (rd_data_s)
    );

    assign not_full_s    = (occ_q < DepthCnt);
    assign issue_hs_s    = valid_o & ready_i;
    assign normal_hs_s   = issue_hs_s & (state_q == NORMAL);
    assign replay_hs_s   = issue_hs_s & (state_q == REPLAY);
    // Only the first retry of a lock episode counts, and only with something in flight.
    assign first_retry_s = retry_valid_i & ~lock_q & (occ_q != '0);
    assign commit_eff_s  = commit_i & (occ_q != '0);
    assign rp_inc_s      = rp_ptr_q + 1'b1;
    assign retry_ready_o = 1'b1;
    assign busy_o        = (state_q == REPLAY);

    // Issue-side outputs: pass-through in NORMAL, buffer read-back in REPLAY.
    always_comb begin
        valid_o = 1'b0;
        ready_o = 1'b0;
        data_o  = data_i;
        id_o    = wr_ptr_q;
        case (state_q)
            REPLAY: begin
                valid_o = 1'b1;
                ready_o = 1'b0;
                data_o  = rd_data_s;
                id_o    = rp_ptr_q;
            end
            NORMAL: begin
                valid_o = valid_i & not_full_s & ~rst_i;
                ready_o = ready_i & not_full_s;
            end
            default: begin
                valid_o = 1'b0;
                ready_o = 1'b0;
            end
        endcase
    end

    // FSM, replay pointer, write pointer and occupancy next-state.
    always_comb begin
        state_d  = state_q;
        rp_ptr_d = rp_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (first_retry_s) begin
            rp_ptr_d = retry_id_i;
            state_d  = REPLAY;
        end else if (replay_hs_s) begin
            rp_ptr_d = rp_inc_s;
            if (rp_inc_s == wr_ptr_q) begin
                state_d = NORMAL;
            end else begin
                state_d = REPLAY;
            end
        end else begin
            state_d = state_q;
        end
        if (normal_hs_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({normal_hs_s, commit_eff_s})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= NORMAL;
            wr_ptr_q <= '0;
            rp_ptr_q <= '0;
            occ_q    <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rp_ptr_q <= rp_ptr_d;
            occ_q    <= occ_d;
            lock_q   <= retry_lock_i;
        end
    end

`ifdef RETRY_SCHED_STATS_EN
    logic [15:0] retry_cnt_q;

    // Saturating count of replays started.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_cnt_q <= 16'h0000;
        end else if (first_retry_s && (retry_cnt_q != 16'hFFFF)) begin
            retry_cnt_q <= retry_cnt_q + 16'h0001;
        end
    end

    assign retry_count_o = retry_cnt_q;
`endif

endmodule
